sram_bank: RTL

//  Parametrised simple-dual-port synchronous SRAM for the replay buffer's storage.
//  It generalises the fixed 8x16 store with configurable width and depth, plus per-byte write enables.
//  A reset-time clear sequencer, a registered read with valid flag, write-first collision bypass
//  and address range checking complete the feature set.

---
 rtl/sram_bank.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bank
//  Description : Parametrised simple-dual-port synchronous SRAM with per-byte
//                write enables, a reset-time clear sequencer, a registered
//                read port with valid flag, write-first collision bypass and
//                address range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bank #(
    parameter int                 DATA_W       = 16,
    parameter int                 ADDR_W       = 3,
    parameter int                 DEPTH        = (1 << ADDR_W),
    parameter int                 CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VAL    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     r_addr,
    input  logic                  oe,
    output wire  [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  init_busy,
    output logic                  addr_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_NBYTES  = DATA_W / 8;
    // Depth widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic              c_CLR_EN  = (CLEAR_ON_RST != 0);

    localparam logic [0:0]        c_S_CLEAR = 1'b0;
    localparam logic [0:0]        c_S_READY = 1'b1;

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt;
    logic [DATA_W-1:0]  r_dout;
    logic               r_valid;
    logic               r_addr_err;

    // ------------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------------
    logic               w_ready;
    logic               w_clr_we;
    logic               w_waddr_ok;
    logic               w_raddr_ok;
    logic               w_any_be;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_collide;
    logic               w_err;
    logic [DATA_W-1:0]  w_old;
    logic [DATA_W-1:0]  w_merged;

    // A pending reset already counts as busy, so requests in that cycle are
    // dropped even if the state register still says READY.
    assign w_ready    = (r_state == c_S_READY) && !rst;
    assign w_clr_we   = (r_state == c_S_CLEAR) && !rst && c_CLR_EN;

    assign w_waddr_ok = ({1'b0, w_addr} < c_DEPTH);
    assign w_raddr_ok = ({1'b0, r_addr} < c_DEPTH);
    assign w_any_be   = |wbe;

    // A write with no byte enabled is a no-op: it neither updates nor errors.
    assign w_wr_ok    = w_ready && we && w_any_be && w_waddr_ok;
    assign w_rd_ok    = w_ready && re;
    assign w_collide  = w_wr_ok && w_raddr_ok && (w_addr == r_addr);
    assign w_err      = w_ready && ((we && w_any_be && !w_waddr_ok) ||
                                    (re && !w_raddr_ok));

    // Old word at the write address; only consumed when the address is valid.
    assign w_old      = r_mem[w_addr];

    // Byte-merged write word, shared by the array update and the read bypass.
    for (genvar k = 0; k < c_NBYTES; k++) begin : g_byte
        assign w_merged[8*k +: 8] = wbe[k] ? din[8*k +: 8] : w_old[8*k +: 8];
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register; reset always restarts the clear phase
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM process 2: next-state logic; leave CLEAR after the last entry is
    // written, or immediately when no clear is requested
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_CLEAR: begin
                if (!c_CLR_EN || (r_cnt == c_LAST)) begin
                    w_state_nxt = c_S_READY;
                end
            end
            c_S_READY: begin
                w_state_nxt = c_S_READY;
            end
            default: begin
                w_state_nxt = c_S_CLEAR;
            end
        endcase
    end

    // FSM process 3: outputs; busy while reset is held or clearing
    always_comb begin
        init_busy = rst || (r_state != c_S_READY);
    end

    // ------------------------------------------------------------------------
    // Clear counter: walks entries 0..DEPTH-1 during the clear phase
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_clr_we) begin
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory array update: clear writes take the whole word, normal writes
    // take the byte-merged word; out-of-range writes never reach here
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= CLEAR_VAL;
        end else if (w_wr_ok) begin
            r_mem[w_addr] <= w_merged;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read port with write-first bypass on a same-address collision
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_rd_ok) begin
                if (!w_raddr_ok) begin
                    r_dout <= '0;
                end else if (w_collide) begin
                    r_dout <= w_merged;
                end else begin
                    r_dout <= r_mem[r_addr];
                end
            end
        end
    end

    // Single-cycle error pulse; both ports out of range still give one pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; the tri-state driver depends only on oe
    // ------------------------------------------------------------------------
    assign dout       = oe ? r_dout : {DATA_W{1'bz}};
    assign dout_valid = r_valid;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire
